// File: rtl/ctrl_conv_stride_output_if.sv
// rtl/ctrl_conv_stride_output_if.sv - control and output handshake bundle for the strided convolution sequencer
interface ctrl_conv_stride_output_if #(
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int CH_WIDTH         = 1
);
  logic                        conv_start;
  logic                        m_ready_y;
  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val;
  logic [CH_WIDTH-1:0]         ch_sel;
  logic                        mac_clear;
  logic                        m_valid_y;
  logic                        conv_done;

  modport master (
    input  conv_start,
    input  m_ready_y,
    output load_xaddr_val,
    output ch_sel,
    output mac_clear,
    output m_valid_y,
    output conv_done
  );

  modport slave (
    output conv_start,
    output m_ready_y,
    input  load_xaddr_val,
    input  ch_sel,
    input  mac_clear,
    input  m_valid_y,
    input  conv_done
  );
endinterface

// File: rtl/ctrl_conv_stride_output.sv
// rtl/ctrl_conv_stride_output.sv - sequences X addresses and channels for a strided multi-filter convolution
module ctrl_conv_stride_output #(
  parameter int X_MEM_SIZE       = 8,
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int STRIDE           = 1,
  parameter int NUM_CH           = 1,
  parameter int CH_WIDTH         = 1,
  parameter int MAC_LATENCY      = 4
) (
  input logic                        clk,
  input logic                        reset,
  ctrl_conv_stride_output_if.master  bus
);

  localparam int NPOS  = (X_MEM_SIZE - F_MEM_SIZE) / STRIDE + 1;
  localparam int CNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [X_MEM_ADDR_WIDTH-1:0] LAST_ADDR = X_MEM_ADDR_WIDTH'((NPOS - 1) * STRIDE);
  localparam logic [X_MEM_ADDR_WIDTH-1:0] ADDR_STEP = X_MEM_ADDR_WIDTH'(STRIDE);
  localparam logic [CH_WIDTH-1:0]         LAST_CH   = CH_WIDTH'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]            CNT_INIT  = CNT_W'(MAC_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_VALID,
    S_DONE
  } state_t;

  state_t                        state, state_n;
  logic                          start_d;
  logic [CNT_W-1:0]              cnt, cnt_n;
  logic [X_MEM_ADDR_WIDTH-1:0]   addr, addr_n;
  logic [CH_WIDTH-1:0]           ch, ch_n;
  logic                          mac_clear_q;
  logic                          valid_q;
  logic                          done_q;

  logic start_rise;
  logic last_out;

  assign start_rise = bus.conv_start && !start_d;
  assign last_out   = (ch == LAST_CH) && (addr == LAST_ADDR);

  assign bus.load_xaddr_val = addr;
  assign bus.ch_sel         = ch;
  assign bus.mac_clear      = mac_clear_q;
  assign bus.m_valid_y      = valid_q;
  assign bus.conv_done      = done_q;

  // State, position/channel counters and the registered strobes derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_d     <= 1'b0;
      cnt         <= '0;
      addr        <= '0;
      ch          <= '0;
      mac_clear_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      start_d     <= bus.conv_start;
      cnt         <= cnt_n;
      addr        <= addr_n;
      ch          <= ch_n;
      mac_clear_q <= (state_n == S_LOAD);
      valid_q     <= (state_n == S_VALID);
      done_q      <= (state_n == S_DONE);
    end
  end

  // Next-state logic: position is the outer loop, channel the inner loop; dropping conv_start aborts a run.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    ch_n    = ch;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          state_n = S_LOAD;
          addr_n  = '0;
          ch_n    = '0;
        end
      end
      S_LOAD: begin
        if (!bus.conv_start) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          addr_n  = '0;
          ch_n    = '0;
        end else begin
          state_n = S_COMPUTE;
          cnt_n   = CNT_INIT;
        end
      end
      S_COMPUTE: begin
        if (!bus.conv_start) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          addr_n  = '0;
          ch_n    = '0;
        end else if (cnt == '0) begin
          state_n = S_VALID;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_VALID: begin
        if (!bus.conv_start) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          addr_n  = '0;
          ch_n    = '0;
        end else if (bus.m_ready_y) begin
          if (last_out) begin
            state_n = S_DONE;
            addr_n  = '0;
            ch_n    = '0;
          end else begin
            state_n = S_LOAD;
            if (ch != LAST_CH) begin
              ch_n = ch + 1'b1;
            end else begin
              ch_n   = '0;
              addr_n = addr + ADDR_STEP;
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        addr_n  = '0;
        ch_n    = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        addr_n  = '0;
        ch_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_conv_stride_output.sv
// tb/tb_ctrl_conv_stride_output.sv - self-checking bench for ctrl_conv_stride_output across three stride/channel configurations
module tb_ctrl_conv_stride_output;

  localparam int XM      = 8;
  localparam int FM      = 4;
  localparam int MAC_LAT = 4;
  localparam int NI      = 3;
  localparam int S_A   [NI] = '{1, 2, 5};
  localparam int NCH_A [NI] = '{1, 2, 1};

  logic clk;
  logic reset;
  logic start;
  logic rdy   [NI];
  logic vld   [NI];
  logic mclr  [NI];
  logic done  [NI];
  logic [7:0] addr [NI];
  logic [7:0] chv  [NI];

  int n_checks;
  int n_errors;
  int idx [NI];
  int mc  [NI];
  int done_cnt;

  ctrl_conv_stride_output_if #(.X_MEM_ADDR_WIDTH(3), .CH_WIDTH(1)) if0 ();
  ctrl_conv_stride_output_if #(.X_MEM_ADDR_WIDTH(3), .CH_WIDTH(1)) if1 ();
  ctrl_conv_stride_output_if #(.X_MEM_ADDR_WIDTH(3), .CH_WIDTH(1)) if2 ();

  ctrl_conv_stride_output u_dut0 (.clk(clk), .reset(reset), .bus(if0));

  ctrl_conv_stride_output #(
    .X_MEM_SIZE(XM), .F_MEM_SIZE(FM), .X_MEM_ADDR_WIDTH(3), .STRIDE(2),
    .NUM_CH(2), .CH_WIDTH(1), .MAC_LATENCY(MAC_LAT)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  ctrl_conv_stride_output #(
    .X_MEM_SIZE(XM), .F_MEM_SIZE(FM), .X_MEM_ADDR_WIDTH(3), .STRIDE(5),
    .NUM_CH(1), .CH_WIDTH(1), .MAC_LATENCY(MAC_LAT)
  ) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.conv_start = start;
  assign if1.conv_start = start;
  assign if2.conv_start = start;
  assign if0.m_ready_y  = rdy[0];
  assign if1.m_ready_y  = rdy[1];
  assign if2.m_ready_y  = rdy[2];

  assign vld[0]  = if0.m_valid_y;
  assign vld[1]  = if1.m_valid_y;
  assign vld[2]  = if2.m_valid_y;
  assign mclr[0] = if0.mac_clear;
  assign mclr[1] = if1.mac_clear;
  assign mclr[2] = if2.mac_clear;
  assign done[0] = if0.conv_done;
  assign done[1] = if1.conv_done;
  assign done[2] = if2.conv_done;
  assign addr[0] = {5'b0, if0.load_xaddr_val};
  assign addr[1] = {5'b0, if1.load_xaddr_val};
  assign addr[2] = {5'b0, if2.load_xaddr_val};
  assign chv[0]  = {7'b0, if0.ch_sel};
  assign chv[1]  = {7'b0, if1.ch_sel};
  assign chv[2]  = {7'b0, if2.ch_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int total_out(input int i);
    return ((XM - FM) / S_A[i] + 1) * NCH_A[i];
  endfunction

  function automatic int exp_addr(input int i, input int k);
    return (k / NCH_A[i]) * S_A[i];
  endfunction

  function automatic int exp_ch(input int i, input int k);
    return k % NCH_A[i];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      idx[i] = 0;
      mc[i]  = 0;
    end
  endtask

  task automatic set_ready(input logic v);
    for (int i = 0; i < NI; i++) rdy[i] = v;
  endtask

  // Scoreboard: every accepted output is compared with the next (address, channel) of the run.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < NI; i++) begin
          if (mclr[i]) mc[i]++;
          if (vld[i] && rdy[i]) begin
            if (idx[i] < total_out(i)) begin
              check($sformatf("hs_addr%0d_k%0d", i, idx[i]), int'(addr[i]), exp_addr(i, idx[i]));
              check($sformatf("hs_ch%0d_k%0d", i, idx[i]), int'(chv[i]), exp_ch(i, idx[i]));
            end else begin
              check($sformatf("extra_out%0d", i), idx[i], total_out(i) - 1);
            end
            idx[i]++;
          end
          if (done[i]) begin
            check($sformatf("done_outs%0d", i), idx[i], total_out(i));
            check($sformatf("done_macclr%0d", i), mc[i], total_out(i));
            idx[i] = 0;
            mc[i]  = 0;
            done_cnt++;
          end
        end
      end
    end
  endtask

  task automatic restart();
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
  endtask

  task automatic wait_done(input int target, input bit rnd);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      if (rnd) begin
        for (int i = 0; i < NI; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      n++;
    end
    check("run_complete", done_cnt, target);
  endtask

  initial begin
    int n;
    int tgt;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    reset    = 1'b1;
    start    = 1'b0;
    set_ready(1'b1);
    clear_model();
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(vld[0]), 0);
    check("rst_macclr", int'(mclr[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_addr", int'(addr[0]), 0);
    check("rst_ch", int'(chv[0]), 0);
    check("rst_valid1", int'(vld[1]), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency to the first output and spacing with ready held high.
    tgt = done_cnt + NI;
    start = 1'b1;
    n = 0;
    while (!vld[0] && n < 50) begin @(posedge clk); #1; n++; end
    check("first_latency", n, MAC_LAT + 2);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!vld[0] && n < 50);
    check("out_spacing", n, MAC_LAT + 2);
    wait_done(tgt, 1'b0);

    // conv_start still high: no second run without a new rising edge.
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (vld[0] || mclr[0]) n++; end
    check("no_rerun", n, 0);

    // Backpressure on the second output of the default configuration.
    tgt = done_cnt + NI;
    restart();
    n = 0;
    while (idx[0] < 1 && n < 100) begin @(posedge clk); #1; n++; end
    rdy[0] = 1'b0;
    n = 0;
    while (!vld[0] && n < 100) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", int'(vld[0]), 1);
      check("hold_addr", int'(addr[0]), S_A[0]);
      check("hold_ch", int'(chv[0]), 0);
      @(posedge clk); #1;
    end
    check("hold_outs", idx[0], 1);
    rdy[0] = 1'b1;
    wait_done(tgt, 1'b0);

    // Abort during COMPUTE of the third output.
    restart();
    n = 0;
    while (idx[0] < 2 && n < 100) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!mclr[0] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clear_model();
    check("abort_valid", int'(vld[0]), 0);
    check("abort_addr", int'(addr[0]), 0);
    check("abort_ch", int'(chv[0]), 0);
    check("abort_valid1", int'(vld[1]), 0);
    n = 0;
    repeat (10) begin @(posedge clk); #1; if (done[0] || done[1] || vld[0]) n++; end
    check("abort_quiet", n, 0);
    tgt = done_cnt + NI;
    restart();
    wait_done(tgt, 1'b0);

    // Randomised backpressure runs.
    for (int r = 0; r < 4; r++) begin
      tgt = done_cnt + NI;
      restart();
      wait_done(tgt, 1'b1);
      set_ready(1'b1);
    end

    // Asynchronous reset while outputs are waiting in VALID.
    set_ready(1'b0);
    restart();
    n = 0;
    while (!vld[0] && n < 100) begin @(posedge clk); #1; n++; end
    check("pre_reset_valid", int'(vld[0]), 1);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", int'(vld[0]), 0);
    check("arst_addr", int'(addr[0]), 0);
    check("arst_macclr", int'(mclr[0]), 0);
    check("arst_valid1", int'(vld[1]), 0);
    #1 reset = 1'b0;
    clear_model();
    set_ready(1'b1);
    tgt = done_cnt + NI;
    wait_done(tgt, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_conv_stride_output.md
CTRL_CONV_STRIDE_OUTPUT -- requirements
Module: ctrl_conv_stride_output

Interface
REQ-001 Parameter X_MEM_SIZE, default 8: number of input samples in X memory.
REQ-002 Parameter F_MEM_SIZE, default 4: taps per filter.
REQ-003 Parameter X_MEM_ADDR_WIDTH, default 3: width of the X address.
REQ-004 Parameter STRIDE, default 1: address step between successive output positions; legal range 1 to X_MEM_SIZE-F_MEM_SIZE+1.
REQ-005 Parameter NUM_CH, default 1: number of filters (output channels) evaluated per position.
REQ-006 Parameter CH_WIDTH, default 1: width of ch_sel; must satisfy 2^CH_WIDTH >= NUM_CH.
REQ-007 Parameter MAC_LATENCY, default 4: cycles from mac_clear to a stable MAC result; legal value >= 1.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 conv_start  input  1  level; high enables the convolution run; its rising edge starts a run.
REQ-011 m_ready_y  input  1  downstream AXI ready for y.
REQ-012 load_xaddr_val  output  X_MEM_ADDR_WIDTH  start X address for the current output.
REQ-013 ch_sel  output  CH_WIDTH  filter/channel index for the current output.
REQ-014 mac_clear  output  1  one-cycle pulse that clears the MAC accumulator.
REQ-015 m_valid_y  output  1  AXI valid for y.
REQ-016 conv_done  output  1  one-cycle pulse after the last y is accepted.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, COMPUTE, VALID and DONE. All outputs SHALL be registered.
REQ-018 Number of positions NPOS SHALL equal (X_MEM_SIZE-F_MEM_SIZE)/STRIDE+1, using integer division. Total outputs per run SHALL equal NPOS*NUM_CH.
REQ-019 Ordering: position is the outer loop and channel is the inner loop. ch_sel SHALL step 0..NUM_CH-1 at each position before load_xaddr_val advances by STRIDE.
REQ-020 IDLE: a rising edge of conv_start (high now, low the previous cycle) SHALL move to LOAD the next cycle, with load_xaddr_val=0 and ch_sel=0.
REQ-021 LOAD lasts exactly 1 cycle. During LOAD, mac_clear=1 and the address/channel outputs are stable. LOAD then moves to COMPUTE.
REQ-022 COMPUTE lasts exactly MAC_LATENCY cycles, counted by a down-counter. COMPUTE then moves to VALID.
REQ-023 VALID: m_valid_y=1. load_xaddr_val and ch_sel SHALL hold until the handshake (m_valid_y && m_ready_y) occurs.
REQ-024 On a handshake that is not the last output: if ch_sel<NUM_CH-1, increment ch_sel; otherwise set ch_sel=0 and add STRIDE to load_xaddr_val. Then go to LOAD.
REQ-025 On the handshake of the last output (ch_sel=NUM_CH-1 and address=(NPOS-1)*STRIDE): go to DONE.
REQ-026 DONE lasts 1 cycle with conv_done=1. In DONE, load_xaddr_val=0 and ch_sel=0. DONE then moves to IDLE.
REQ-027 A new run SHALL require conv_start to fall and then rise again.
REQ-028 m_valid_y SHALL be low in every state except VALID. It SHALL never drop without a handshake, except on abort.
REQ-029 Abort: conv_start low in LOAD, COMPUTE or VALID SHALL return the block to IDLE on the next edge. On abort: m_valid_y=0, counters cleared, and no conv_done.
REQ-030 Minimum latency from the start edge to the first m_valid_y SHALL be 2+MAC_LATENCY cycles.
REQ-031 If m_ready_y is held high, consecutive outputs SHALL be spaced exactly MAC_LATENCY+2 cycles apart.
REQ-032 Address arithmetic SHALL never exceed X_MEM_SIZE-F_MEM_SIZE and never wrap.

Reset
REQ-033 When reset is asserted, asynchronously: state=IDLE, load_xaddr_val=0, ch_sel=0, mac_clear=0, m_valid_y=0, conv_done=0, conv_start history=0, counters=0.
REQ-034 Reset asserted mid-run SHALL abandon the run. After reset is released, conv_start already high SHALL count as a rising edge.

Verification
REQ-035 Defaults, m_ready_y=1, conv_start held high -> five outputs with addresses 0,1,2,3,4. First m_valid_y appears 6 cycles after the start edge. conv_done pulses once, the cycle after the fifth handshake.
REQ-036 X_MEM_SIZE=8, F_MEM_SIZE=4, STRIDE=2, NUM_CH=2 -> six outputs with (address,ch_sel) = (0,0),(0,1),(2,0),(2,1),(4,0),(4,1). mac_clear pulses six times.
REQ-037 m_ready_y low for 5 cycles on the second output -> m_valid_y, address and ch_sel held steady. There is no extra output and no skipped output.
REQ-038 conv_start dropped during COMPUTE of the third output -> state returns to IDLE, m_valid_y=0, and no conv_done. A later rising edge restarts at address 0, ch_sel 0.
REQ-039 Asynchronous reset pulse while in VALID, not aligned to clk -> all outputs are 0 immediately. With conv_start still high after release, the run restarts at address 0.
REQ-040 STRIDE=5 with X_MEM_SIZE=8, F_MEM_SIZE=4 -> NPOS=1, so exactly one output at address 0, then conv_done.
